// File: rtl/vslc_timer_bank.sv
// vslc_timer_bank: NCH independent timers (cycle, one-shot, TON, TOF)
// sharing one free-running prescaler.
module vslc_timer_bank #(
   parameter  int NCH   = 4,
   parameter  int CNT_W = 10,
   parameter  int DIV_W = 4,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_data,
   input  logic [NCH-1:0]   ch_en,
   output logic [NCH-1:0]   tmr_out,
   output logic [NCH-1:0]   tmr_busy,
   output logic [NCH-1:0]   tmr_done
);
   localparam int PRE_W = (1 << DIV_W) - 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_A    = 2'd1;
   localparam logic [1:0] ST_B    = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [1:0] M_CYCLE   = 2'd0;
   localparam logic [1:0] M_ONESHOT = 2'd1;
   localparam logic [1:0] M_TON     = 2'd2;
   localparam logic [1:0] M_TOF     = 2'd3;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [NCH-1:0]   en_q, en_d;
   logic [NCH-1:0]   out_q, out_d;
   logic [NCH-1:0]   done_q, done_d;
   logic [1:0]       st_q   [NCH];
   logic [1:0]       st_d   [NCH];
   logic [CNT_W-1:0] cnt_q  [NCH];
   logic [CNT_W-1:0] cnt_d  [NCH];
   logic [CNT_W-1:0] pa_q   [NCH];
   logic [CNT_W-1:0] pa_d   [NCH];
   logic [CNT_W-1:0] pb_q   [NCH];
   logic [CNT_W-1:0] pb_d   [NCH];
   logic [1:0]       mode_q [NCH];
   logic [1:0]       mode_d [NCH];
   logic [DIV_W-1:0] div_q  [NCH];
   logic [DIV_W-1:0] div_d  [NCH];

   function automatic logic tick_of(input logic [PRE_W-1:0] pre,
                                    input logic [DIV_W-1:0] dv);
      logic t;
      t = 1'b1;
      for (int b = 0; b < PRE_W; b++)
         if (b < int'(dv) && !pre[b]) t = 1'b0;
      return t;
   endfunction

   // Phase entry with zero-length phases skipped; returns {state, out}.
   function automatic logic [2:0] go_a(input logic [CNT_W-1:0] pa,
                                       input logic [CNT_W-1:0] pb);
      if (pa != '0) return {ST_A, 1'b0};
      if (pb != '0) return {ST_B, 1'b1};
      return {ST_IDLE, 1'b0};
   endfunction

   function automatic logic [2:0] go_b(input logic [CNT_W-1:0] pa,
                                       input logic [CNT_W-1:0] pb);
      if (pb != '0) return {ST_B, 1'b1};
      if (pa != '0) return {ST_A, 1'b0};
      return {ST_IDLE, 1'b0};
   endfunction

   always_comb begin : nxt
      logic [CNT_W:0] cnt1;
      logic           tick, end_a, end_b;
      logic           en, rise, fall, wr;
      logic [2:0]     nx;
      pre_d  = pre_q + PRE_W'(1);
      en_d   = ch_en;
      out_d  = out_q;
      done_d = '0;
      for (int i = 0; i < NCH; i++) begin
         st_d[i]   = st_q[i];
         cnt_d[i]  = cnt_q[i];
         pa_d[i]   = pa_q[i];
         pb_d[i]   = pb_q[i];
         mode_d[i] = mode_q[i];
         div_d[i]  = div_q[i];
         en    = ch_en[i];
         rise  = en & ~en_q[i];
         fall  = ~en & en_q[i];
         tick  = tick_of(pre_q, div_q[i]);
         cnt1  = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
         end_a = tick && (cnt1 >= {1'b0, pa_q[i]});
         end_b = tick && (cnt1 >= {1'b0, pb_q[i]});
         nx    = {st_q[i], out_q[i]};
         unique case (mode_q[i])
            M_CYCLE: begin
               if (!en) begin
                  nx = {ST_IDLE, 1'b0};
                  cnt_d[i] = '0;
               end else begin
                  unique case (st_q[i])
                     ST_IDLE: begin
                        nx = go_a(pa_q[i], pb_q[i]);
                        cnt_d[i] = '0;
                     end
                     ST_A: begin
                        if (end_a) begin
                           nx = go_b(pa_q[i], pb_q[i]);
                           cnt_d[i] = '0;
                        end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                     end
                     ST_B: begin
                        if (end_b) begin
                           nx = go_a(pa_q[i], pb_q[i]);
                           cnt_d[i] = '0;
                        end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                     end
                     default: begin
                        nx = {ST_IDLE, 1'b0};
                        cnt_d[i] = '0;
                     end
                  endcase
               end
            end
            M_ONESHOT: begin
               unique case (st_q[i])
                  ST_IDLE: begin
                     if (rise) begin
                        nx = go_a(pa_q[i], pb_q[i]);
                        cnt_d[i] = '0;
                        done_d[i] = (pa_q[i] == '0) && (pb_q[i] == '0);
                     end
                  end
                  ST_A: begin
                     if (end_a) begin
                        cnt_d[i] = '0;
                        if (pb_q[i] != '0) nx = {ST_B, 1'b1};
                        else begin
                           nx = {ST_IDLE, 1'b0};
                           done_d[i] = 1'b1;
                        end
                     end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                  end
                  ST_B: begin
                     if (end_b) begin
                        nx = {ST_IDLE, 1'b0};
                        cnt_d[i] = '0;
                        done_d[i] = 1'b1;
                     end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                  end
                  default: begin
                     nx = {ST_IDLE, 1'b0};
                     cnt_d[i] = '0;
                  end
               endcase
            end
            M_TON: begin
               if (!en) begin
                  nx = {ST_IDLE, 1'b0};
                  cnt_d[i] = '0;
               end else begin
                  unique case (st_q[i])
                     ST_IDLE: begin
                        cnt_d[i] = '0;
                        if (pa_q[i] == '0) begin
                           nx = {ST_HOLD, 1'b1};
                           done_d[i] = 1'b1;
                        end else nx = {ST_A, 1'b0};
                     end
                     ST_A: begin
                        if (end_a) begin
                           nx = {ST_HOLD, 1'b1};
                           cnt_d[i] = '0;
                           done_d[i] = 1'b1;
                        end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                     end
                     ST_HOLD: ;
                     default: begin
                        nx = {ST_IDLE, 1'b0};
                        cnt_d[i] = '0;
                     end
                  endcase
               end
            end
            default: begin
               if (en) begin
                  nx = {ST_HOLD, 1'b1};
                  cnt_d[i] = '0;
               end else begin
                  unique case (st_q[i])
                     ST_HOLD: begin
                        if (fall) begin
                           cnt_d[i] = '0;
                           if (pb_q[i] != '0) nx = {ST_B, 1'b1};
                           else begin
                              nx = {ST_IDLE, 1'b0};
                              done_d[i] = 1'b1;
                           end
                        end
                     end
                     ST_B: begin
                        if (end_b) begin
                           nx = {ST_IDLE, 1'b0};
                           cnt_d[i] = '0;
                           done_d[i] = 1'b1;
                        end else if (tick) cnt_d[i] = cnt1[CNT_W-1:0];
                     end
                     default: begin
                        nx = {ST_IDLE, 1'b0};
                        cnt_d[i] = '0;
                     end
                  endcase
               end
            end
         endcase
         st_d[i]  = nx[2:1];
         out_d[i] = nx[0];
         // A mode/div write overrides whatever the channel was about to do.
         wr = cfg_we && (cfg_ch == CH_W'(i));
         if (wr) begin
            unique case (cfg_addr)
               2'd0: pa_d[i] = cfg_data;
               2'd1: pb_d[i] = cfg_data;
               2'd2: begin
                  mode_d[i] = cfg_data[DIV_W+1:DIV_W];
                  div_d[i]  = cfg_data[DIV_W-1:0];
                  st_d[i]   = ST_IDLE;
                  cnt_d[i]  = '0;
                  out_d[i]  = 1'b0;
                  done_d[i] = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         en_q   <= '0;
         out_q  <= '0;
         done_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            st_q[i]   <= ST_IDLE;
            cnt_q[i]  <= '0;
            pa_q[i]   <= CNT_W'(1);
            pb_q[i]   <= CNT_W'(2);
            mode_q[i] <= M_CYCLE;
            div_q[i]  <= '0;
         end
      end else begin
         pre_q  <= pre_d;
         en_q   <= en_d;
         out_q  <= out_d;
         done_q <= done_d;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         pa_q   <= pa_d;
         pb_q   <= pb_d;
         mode_q <= mode_d;
         div_q  <= div_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++)
         tmr_busy[i] = (st_q[i] != ST_IDLE);
   end

   assign tmr_out  = out_q;
   assign tmr_done = done_q;

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Bench for vslc_timer_bank: directed scenarios plus random traffic,
// all checked every cycle against a phase-level channel model.
`timescale 1ns/1ps
module tb_vslc_timer_bank;
   localparam int NCH   = 4;
   localparam int CNT_W = 10;
   localparam int DIV_W = 4;
   localparam int IDLE = 0, LOW = 1, HIGH = 2, HOLD = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_we = 1'b0;
   logic [1:0]       cfg_ch = '0;
   logic [1:0]       cfg_addr = '0;
   logic [CNT_W-1:0] cfg_data = '0;
   logic [NCH-1:0]   ch_en = '0;
   logic [NCH-1:0]   tmr_out, tmr_busy, tmr_done;

   vslc_timer_bank #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ch_en(ch_en),
      .tmr_out(tmr_out), .tmr_busy(tmr_busy), .tmr_done(tmr_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int m_ph[NCH], m_el[NCH], m_pa[NCH], m_pb[NCH];
   int m_mode[NCH], m_div[NCH];
   bit m_done[NCH], m_enq[NCH];
   int m_pre;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit out_of(input int mode, input int ph);
      case (mode)
         0, 1:    return ph == HIGH;
         2:       return ph == HOLD;
         default: return ph == HOLD || ph == HIGH;
      endcase
   endfunction

   function automatic int cyc_enter(input int want, input int pa,
                                    input int pb);
      if (pa == 0 && pb == 0) return IDLE;
      if (want == LOW) return (pa == 0) ? HIGH : LOW;
      return (pb == 0) ? LOW : HIGH;
   endfunction

   task automatic model_reset();
      m_pre = 0;
      for (int i = 0; i < NCH; i++) begin
         m_ph[i] = IDLE; m_el[i] = 0; m_pa[i] = 1; m_pb[i] = 2;
         m_mode[i] = 0; m_div[i] = 0; m_done[i] = 0; m_enq[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         bit en, rise, fall, tick, lo_end, hi_end, moved, dn;
         int span, ph, nph, pa, pb;
         en = ch_en[i];
         rise = en && !m_enq[i];
         fall = !en && m_enq[i];
         span = 1 << m_div[i];
         tick = (m_pre % span) == span - 1;
         lo_end = tick && (m_el[i] + 1 >= m_pa[i]);
         hi_end = tick && (m_el[i] + 1 >= m_pb[i]);
         pa = m_pa[i]; pb = m_pb[i];
         ph = m_ph[i]; nph = ph; moved = 1; dn = 0;
         case (m_mode[i])
            0: begin
               if (!en) nph = IDLE;
               else if (ph == IDLE) nph = cyc_enter(LOW, pa, pb);
               else if (ph == LOW && lo_end) nph = cyc_enter(HIGH, pa, pb);
               else if (ph == HIGH && hi_end) nph = cyc_enter(LOW, pa, pb);
               else if (ph == HOLD) nph = IDLE;
               else moved = 0;
            end
            1: begin
               if (ph == IDLE && rise) begin
                  nph = (pa != 0) ? LOW : ((pb != 0) ? HIGH : IDLE);
                  dn = (pa == 0 && pb == 0);
               end else if (ph == LOW && lo_end) begin
                  nph = (pb != 0) ? HIGH : IDLE;
                  dn = (pb == 0);
               end else if (ph == HIGH && hi_end) begin
                  nph = IDLE; dn = 1;
               end else if (ph == HOLD) nph = IDLE;
               else moved = 0;
            end
            2: begin
               if (!en) nph = IDLE;
               else if (ph == IDLE) begin
                  nph = (pa == 0) ? HOLD : LOW;
                  dn = (pa == 0);
               end else if (ph == LOW && lo_end) begin
                  nph = HOLD; dn = 1;
               end else if (ph == HIGH) nph = IDLE;
               else moved = 0;
            end
            default: begin
               if (en) nph = HOLD;
               else if (ph == HOLD && fall) begin
                  nph = (pb != 0) ? HIGH : IDLE;
                  dn = (pb == 0);
               end else if (ph == HIGH && hi_end) begin
                  nph = IDLE; dn = 1;
               end else if (ph == LOW) nph = IDLE;
               else moved = 0;
            end
         endcase
         if (moved) m_el[i] = 0;
         else if (tick && (ph == LOW || ph == HIGH)) m_el[i]++;
         if (cfg_we && int'(cfg_ch) == i) begin
            case (cfg_addr)
               2'd0: m_pa[i] = int'(cfg_data);
               2'd1: m_pb[i] = int'(cfg_data);
               2'd2: begin
                  m_mode[i] = int'(cfg_data[DIV_W+1:DIV_W]);
                  m_div[i] = int'(cfg_data[DIV_W-1:0]);
                  nph = IDLE; m_el[i] = 0; dn = 0;
               end
               default: ;
            endcase
         end
         m_ph[i] = nph;
         m_done[i] = dn;
         m_enq[i] = en;
      end
      m_pre = (m_pre + 1) % (1 << ((1 << DIV_W) - 1));
   endtask

   task automatic compare();
      logic [NCH-1:0] eo, eb, ed;
      for (int i = 0; i < NCH; i++) begin
         eo[i] = out_of(m_mode[i], m_ph[i]);
         eb[i] = (m_ph[i] != IDLE);
         ed[i] = m_done[i];
      end
      chk("tmr_out", 32'(tmr_out), 32'(eo));
      chk("tmr_busy", 32'(tmr_busy), 32'(eb));
      chk("tmr_done", 32'(tmr_done), 32'(ed));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic wr(input int ch, input int addr, input int data);
      cfg_we = 1'b1;
      cfg_ch = 2'(ch);
      cfg_addr = 2'(addr);
      cfg_data = CNT_W'(data);
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] pat1;
      logic [3:0] o4, d4;
      logic [5:0] pat6;
      int hi, dn, first, r1, f1, r2, k;
      bit v[40];

      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", 32'(tmr_out), 32'd0);
      chk("reset_busy", 32'(tmr_busy), 32'd0);
      chk("reset_done", 32'(tmr_done), 32'd0);
      rst_n = 1'b1;

      // CYCLE on ch0: low 2, high 3
      wr(0, 0, 2); wr(0, 1, 3); wr(0, 2, 0);
      pat1 = 10'b1110011100;
      ch_en[0] = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         chk("cycle_seq", 32'(tmr_out[0]), 32'(pat1[e]));
      end
      ch_en[0] = 1'b0;
      step();
      chk("cycle_off_out", 32'(tmr_out[0]), 32'd0);
      chk("cycle_off_busy", 32'(tmr_busy[0]), 32'd0);

      // ONESHOT on ch1 with retrigger while busy
      wr(1, 0, 1); wr(1, 1, 4); wr(1, 2, 16);
      hi = 0; dn = 0;
      for (int s = 0; s < 10; s++) begin
         ch_en[1] = (s == 0 || s == 2);
         step();
         hi += int'(tmr_out[1]);
         dn += int'(tmr_done[1]);
      end
      chk("oneshot_high_cycles", 32'(hi), 32'd4);
      chk("oneshot_done_count", 32'(dn), 32'd1);
      chk("oneshot_idle_after", 32'(tmr_busy[1]), 32'd0);

      // TON on ch2: short attempt, then long attempt
      wr(2, 0, 5); wr(2, 2, 32);
      hi = 0;
      ch_en[2] = 1'b1;
      repeat (3) begin
         step();
         hi += int'(tmr_out[2]);
      end
      ch_en[2] = 1'b0;
      step();
      chk("ton_short_no_out", 32'(hi), 32'd0);
      ch_en[2] = 1'b1;
      first = -1; dn = 0;
      for (int s = 0; s < 8; s++) begin
         step();
         if (tmr_out[2] && first < 0) first = s;
         dn += int'(tmr_done[2]);
      end
      chk("ton_first_high", 32'(first), 32'd5);
      chk("ton_done_count", 32'(dn), 32'd1);
      ch_en[2] = 1'b0;
      step();
      chk("ton_release_out", 32'(tmr_out[2]), 32'd0);

      // TOF on ch3, then re-raise in the middle of the off-delay
      wr(3, 1, 3); wr(3, 2, 48);
      ch_en[3] = 1'b1;
      step();
      chk("tof_on_next_edge", 32'(tmr_out[3]), 32'd1);
      step();
      ch_en[3] = 1'b0;
      for (int s = 0; s < 4; s++) begin
         step();
         o4[s] = tmr_out[3];
         d4[s] = tmr_done[3];
      end
      chk("tof_off_seq", 32'(o4), 32'h7);
      chk("tof_done_seq", 32'(d4), 32'h8);
      ch_en[3] = 1'b1;
      step();
      ch_en[3] = 1'b0;
      step(); step();
      ch_en[3] = 1'b1;
      step();
      chk("tof_rehold_busy", 32'(tmr_busy[3]), 32'd1);
      ch_en[3] = 1'b0;
      for (int s = 0; s < 4; s++) begin
         step();
         o4[s] = tmr_out[3];
         d4[s] = tmr_done[3];
      end
      chk("tof_restart_seq", 32'(o4), 32'h7);
      chk("tof_restart_done", 32'(d4), 32'h8);

      // Prescaled CYCLE on ch0: div 2, low 1 tick, high 2 ticks
      wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 2);
      ch_en[0] = 1'b1;
      for (int s = 0; s < 40; s++) begin
         step();
         v[s] = tmr_out[0];
      end
      r1 = -1; f1 = -1; r2 = -1;
      for (int s = 1; s < 40; s++) begin
         if (r1 < 0 && !v[s-1] && v[s]) r1 = s;
         else if (r1 >= 0 && f1 < 0 && v[s-1] && !v[s]) f1 = s;
         else if (f1 >= 0 && r2 < 0 && !v[s-1] && v[s]) r2 = s;
      end
      chk("presc_found", 32'(r2 > 0), 32'd1);
      chk("presc_high_len", 32'(f1 - r1), 32'd8);
      chk("presc_low_len", 32'(r2 - f1), 32'd4);
      wr(0, 2, 2);
      chk("abort_out", 32'(tmr_out[0]), 32'd0);
      chk("abort_busy", 32'(tmr_busy[0]), 32'd0);
      chk("abort_done", 32'(tmr_done[0]), 32'd0);
      ch_en[0] = 1'b0;
      step();

      // Async reset in the middle of the high phase
      wr(0, 0, 3); wr(0, 1, 5); wr(0, 2, 0);
      ch_en = 4'b0001;
      k = 0;
      while (!tmr_out[0] && k < 20) begin
         step();
         k++;
      end
      chk("reset_setup_high", 32'(tmr_out[0]), 32'd1);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", 32'(tmr_out), 32'd0);
      chk("async_reset_busy", 32'(tmr_busy), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pat6 = 6'b110110;
      for (int s = 0; s < 6; s++) begin
         step();
         chk("post_reset_seq", 32'(tmr_out[0]), 32'(pat6[s]));
      end

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 5) == 0) ch_en[i] = ~ch_en[i];
         cfg_we = ($urandom_range(0, 5) == 0);
         cfg_ch = 2'($urandom_range(0, NCH - 1));
         cfg_addr = 2'($urandom_range(0, 3));
         if (cfg_addr == 2'd2)
            cfg_data = CNT_W'(($urandom_range(0, 3) << DIV_W)
                              | $urandom_range(0, 2));
         else if (cfg_addr == 2'd3)
            cfg_data = CNT_W'($urandom);
         else
            cfg_data = CNT_W'($urandom_range(0, 6));
         step();
      end
      cfg_we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vslc_timer_bank.md
# vslc_timer_bank

Multi-channel hardware timer bank for the VSLC ladder-logic core. It replaces the single hard-wired PWM/one-shot timer with NCH independent channels. Each channel is configurable as a free-running cycle timer, a one-shot, an on-delay (TON) or an off-delay (TOF). The bank sits beside the stack executor: the executor drives each channel's `ch_en` level from pops to the timer register and loads periods through a simple write port. Channel outputs are muxed back into `uo_out`.

## Interface
Parameters:
- NCH, 4, number of timer channels (1..16)
- CNT_W, 10, width of period registers and per-channel tick counter
- DIV_W, 4, width of per-channel prescale select; shared prescaler width PRE_W = 2^DIV_W − 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  max(1,$clog2(NCH))  target channel; values ≥ NCH are ignored
- cfg_addr  in  2  0 = period_a, 1 = period_b, 2 = {mode[1:0], div[DIV_W-1:0]} in low bits, 3 = reserved (write ignored)
- cfg_data  in  CNT_W  write data
- ch_en  in  NCH  per-channel run/trigger level
- tmr_out  out  NCH  registered timer outputs
- tmr_busy  out  NCH  channel state ≠ IDLE
- tmr_done  out  NCH  one-cycle completion pulse

## Operation
- Reset values (async): tmr_out = 0, tmr_busy = 0, tmr_done = 0, ch_en_q = 0, prescaler = 0.
- Reset values per channel: state IDLE, cnt 0, period_a = 1, period_b = 2, mode = 0 (CYCLE), div = 0.
- Prescaler: one free-running PRE_W-bit counter is shared by all channels.
- Channel tick: tick_i = (div_i == 0) ? 1 : &pre[div_i-1:0]. A tick occurs every 2^div_i cycles; its alignment is relative to the shared prescaler, not to the start.
- Counting rule: in phases A and B the counter counts ticks, cnt <= cnt + 1. The phase ends at the edge where the counted tick makes cnt+1 ≥ period; cnt then clears.
- A phase whose period is 0 is skipped: zero length, output unchanged.
- Channel states: IDLE, A (out = 0), B (out = 1), HOLD (TON/TOF output held, not counting).
- ch_en_q is registered ch_en. rise = ch_en & ~ch_en_q; fall = ~ch_en & ch_en_q.
- Mode 0 CYCLE:
  - ch_en high in IDLE → A.
  - A ends → B, out = 1. B ends → A, out = 0. This repeats.
  - ch_en low in any state → IDLE, out = 0, next edge.
  - period_a = period_b = 0: the channel stays IDLE.
- Mode 1 ONESHOT:
  - rise in IDLE → A, then B, then IDLE with out = 0 and tmr_done pulse.
  - Retrigger while busy is ignored. ch_en low does not abort.
  - period_b = 0: out never asserts; done still pulses.
- Mode 2 TON:
  - ch_en high in IDLE → A.
  - A ends → HOLD, out = 1, tmr_done pulse.
  - ch_en low in A or HOLD → IDLE, out = 0, cnt = 0, next edge.
  - period_a = 0 → HOLD on the first cycle.
- Mode 3 TOF:
  - ch_en high → HOLD, out = 1, next edge, from any state.
  - fall → B (out stays 1).
  - B ends → IDLE, out = 0, tmr_done pulse.
  - ch_en high during B → HOLD, cnt = 0.
  - period_b = 0 → IDLE on fall.
- Config writes:
  - A period write applies immediately to the live compare. If cnt ≥ new period − 1, the phase ends on the next tick.
  - An addr-2 write to a busy channel aborts it: IDLE, out = 0, no done.
  - If the addr-2 write coincides with a ch_en edge on the same channel, the write wins and the edge is discarded (ch_en_q still updates).
- Channels are fully independent. Simultaneous writes and events on different channels do not interact.

## Timing
- ch_en is sampled at edge k. The state change is visible after edge k; the first countable tick is at edge k+1.
- CYCLE steady state: out low for period_a·2^div cycles and high for period_b·2^div cycles.
- tmr_done is high for exactly one cycle, coincident with the out transition that completes the function.
- No combinational path from inputs to outputs.
- Reset mid-operation: outputs go to 0 immediately, asynchronously. Operation resumes from the reset config.

## Test plan
- CYCLE, NCH = 4, ch0: div 0, period_a = 2, period_b = 3, ch_en0 raised at edge 0 → tmr_out[0] after edges 0..9 = 0,0,1,1,1,0,0,1,1,1; ch_en0 low → out 0 and busy 0 next edge.
- ONESHOT ch1: div 0, period_a = 1, period_b = 4, pulse ch_en1 for 1 cycle, retrigger at +2 → out high for exactly 4 cycles, done pulses once, retrigger ignored.
- TON ch2: period_a = 5. ch_en2 high for 3 cycles, then low, then high for 8 cycles → first attempt no out; second attempt out = 1 after the 5th counted edge, done once, out = 0 one edge after ch_en2 falls.
- TOF ch3: period_b = 3. ch_en3 high → out 1 next edge; fall → out stays 1 for 3 edges, then 0 with done. Re-raise mid-B → HOLD, count restarts.
- Prescale: CYCLE div = 2, period_a = 1, period_b = 2 → steady-state high 8 cycles, low 4. Mode rewrite while busy → immediate IDLE, out 0, no done.
- Async reset asserted mid-B between clock edges → all tmr_out = 0 before the next edge; after release, period_a reads back as 1 (a CYCLE run shows low 1, high 2).
